// File: rtl/reg_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_queue
// Purpose  : Circular FIFO of pending register-file writes {dest, value}.
//            The head entry is presented to the register file every cycle
//            it exists and is retired on the following posedge. Writes to
//            register 0 are accepted but discarded.
//            Optional store-to-read forwarding lookup for two source
//            indices, compiled in only when WBQ_FORWARD_EN is defined.
// Macro    : WBQ_FORWARD_EN (undefined by default -> fwd outputs tied to 0)
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_queue #(
  parameter int DEPTH = 4,   // entries, power of two in 2..16
  parameter int CW    = 3    // count width, log2(DEPTH)+1
) (
  input  logic          clk,
  input  logic          rst,            // asynchronous, active-low
  // producer side
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_dest,
  input  logic [31:0]   in_value,
  // register-file side
  output logic          rf_write_en,
  output logic [4:0]    rf_dest,
  output logic [31:0]   rf_write_value,
  // forwarding lookup
  input  logic [4:0]    src1,
  input  logic [4:0]    src2,
  output logic          fwd1_hit,
  output logic          fwd2_hit,
  output logic [31:0]   fwd1_value,
  output logic [31:0]   fwd2_value,
  // status
  output logic [CW-1:0] count,
  output logic          empty
);

  // Pointer width; DEPTH is a power of two so pointers wrap naturally.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage; contents are meaningful only between head and tail.
  logic [4:0]    dest_mem_q  [DEPTH];
  logic [31:0]   value_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;

  // Handshake, push/pop decisions and next pointer/count values.
  always_comb begin
    in_ready = (count_q != CW'(DEPTH));
    empty    = (count_q == '0);
    // A write to register 0 completes the handshake but is never stored.
    push     = in_valid && in_ready && (in_dest != 5'd0);
    // The register file always accepts, so any head entry retires now.
    pop      = !empty;

    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;   // idle, or push and pop together
    endcase
  end

  // Pointer and occupancy state; reset drops every pending entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail; no reset needed since count guards it.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem_q[tail_q]  <= in_dest;
      value_mem_q[tail_q] <= in_value;
    end
  end

  // Head entry drives the register file; outputs forced to 0 when empty.
  always_comb begin
    rf_write_en    = pop;
    rf_dest        = 5'd0;
    rf_write_value = 32'd0;
    if (pop) begin
      rf_dest        = dest_mem_q[head_q];
      rf_write_value = value_mem_q[head_q];
    end
  end

  assign count = count_q;

`ifdef WBQ_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Scan occupied entries oldest to youngest so the last match (nearest
  // the tail) wins. Only stored entries are visible, never the in_* write.
  always_comb begin
    fwd1_hit   = 1'b0;
    fwd2_hit   = 1'b0;
    fwd1_value = 32'd0;
    fwd2_value = 32'd0;
    fwd_idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((src1 != 5'd0) && (dest_mem_q[fwd_idx] == src1)) begin
          fwd1_hit   = 1'b1;
          fwd1_value = value_mem_q[fwd_idx];
        end
        if ((src2 != 5'd0) && (dest_mem_q[fwd_idx] == src2)) begin
          fwd2_hit   = 1'b1;
          fwd2_value = value_mem_q[fwd_idx];
        end
      end
    end
  end
`else
  // Forwarding not built: lookup indices are intentionally ignored.
  logic unused_src;
  assign unused_src = ^{src1, src2};

  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
  assign fwd1_value = 32'd0;
  assign fwd2_value = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_queue
// Purpose  : Self-checking bench for reg_write_queue: a vector table for the
//            directed cases, a reference FIFO scoreboard for every cycle, and
//            hand-written sequences for random bursts and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_dest;
  logic [31:0]   in_value;
  logic          rf_write_en;
  logic [4:0]    rf_dest;
  logic [31:0]   rf_write_value;
  logic [4:0]    src1;
  logic [4:0]    src2;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [31:0]   fwd1_value;
  logic [31:0]   fwd2_value;
  logic [CW-1:0] count;
  logic          empty;

  reg_write_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dest        (in_dest),
    .in_value       (in_value),
    .rf_write_en    (rf_write_en),
    .rf_dest        (rf_dest),
    .rf_write_value (rf_write_value),
    .src1           (src1),
    .src2           (src2),
    .fwd1_hit       (fwd1_hit),
    .fwd2_hit       (fwd2_hit),
    .fwd1_value     (fwd1_value),
    .fwd2_value     (fwd2_value),
    .count          (count),
    .empty          (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } entry_t;

  typedef struct {
    logic        vld;
    logic [4:0]  d;
    logic [31:0] val;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] rv;
    logic [2:0]  cnt;
    logic        f1h;
    logic [31:0] f1v;
    logic        f2h;
    logic [31:0] f2v;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[13];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Youngest stored entry matching s; bit 32 is the hit flag.
  function automatic logic [32:0] model_fwd(input logic [4:0] s);
    logic [32:0] r;
    r = 33'd0;
    if (s != 5'd0) begin
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].d == s) r = {1'b1, sb[i].v};
      end
    end
    return r;
  endfunction

  // Compare every output against the reference FIFO (call mid-cycle).
  task automatic sb_check();
    logic [32:0] f1;
    logic [32:0] f2;
    chk("count", 32'(count), 32'(sb.size()));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    chk("rf_write_en", 32'(rf_write_en), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("rf_dest", 32'(rf_dest), 32'(sb[0].d));
      chk("rf_write_value", rf_write_value, sb[0].v);
    end else begin
      chk("rf_dest_idle", 32'(rf_dest), 32'd0);
      chk("rf_write_value_idle", rf_write_value, 32'd0);
    end
    f1 = model_fwd(src1);
    f2 = model_fwd(src2);
    chk("fwd1_hit", 32'(fwd1_hit), FWD ? 32'(f1[32]) : 32'd0);
    chk("fwd1_value", fwd1_value, FWD ? f1[31:0] : 32'd0);
    chk("fwd2_hit", 32'(fwd2_hit), FWD ? 32'(f2[32]) : 32'd0);
    chk("fwd2_value", fwd2_value, FWD ? f2[31:0] : 32'd0);
  endtask

  // Advance the reference FIFO at the posedge (inputs still stable).
  task automatic sb_update();
    bit acc;
    acc = in_valid && (sb.size() != DEPTH);
    if (sb.size() != 0) void'(sb.pop_front());
    if (acc && in_dest != 5'd0) sb.push_back('{in_dest, in_value});
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] val,
                       input logic [4:0] s1, input logic [4:0] s2);
    in_valid = v;
    in_dest  = d;
    in_value = val;
    src1     = s1;
    src2     = s2;
  endtask

  task automatic step(input logic v, input logic [4:0] d, input logic [31:0] val,
                      input logic [4:0] s1, input logic [4:0] s2);
    drive(v, d, val, s1, s2);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    sb_update();
    #1;
  endtask

  initial begin
    logic [4:0] last_d;

    //          vld d      val           s1     s2     en rd     rv            cnt f1h f1v           f2h f2v
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd3,  1'b1, 5'd5,  32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd0,  1'b1, 5'd7,  32'h11,       3'd1, 1'b1, 32'h11,       1'b0, 32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b1, 5'd7,  32'h22,       3'd1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b1, 5'd1,  32'hA5A5A5A5, 5'd31, 5'd1,  1'b1, 5'd31, 32'hFFFFFFFF, 3'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  1'b1, 5'd1,  32'hA5A5A5A5, 3'd1, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};

    // Reset state
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1 rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].vld, vecs[i].d, vecs[i].val, vecs[i].s1, vecs[i].s2);
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), 32'(rf_write_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d_rf_dest", i), 32'(rf_dest), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_rf_value", i), rf_write_value, vecs[i].rv);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d_fwd1_hit", i), 32'(fwd1_hit), FWD ? 32'(vecs[i].f1h) : 32'd0);
      chk($sformatf("vec%0d_fwd1_value", i), fwd1_value, FWD ? vecs[i].f1v : 32'd0);
      chk($sformatf("vec%0d_fwd2_hit", i), 32'(fwd2_hit), FWD ? 32'(vecs[i].f2h) : 32'd0);
      chk($sformatf("vec%0d_fwd2_value", i), fwd2_value, FWD ? vecs[i].f2v : 32'd0);
      sb_check();
      @(posedge clk);
      sb_update();
      #1;
    end

    // Continuous burst with random gaps and occasional zero-register writes
    last_d = 5'd0;
    for (int i = 0; i < 40; i++) begin
      logic       v;
      logic [4:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = 5'($urandom_range(0, 31));
      step(v, d, $urandom, last_d, 5'($urandom_range(0, 31)));
      chk("count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
      chk("ready_vs_count", 32'(in_ready), 32'(count != CW'(DEPTH)));
      if (v) last_d = d;
    end
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Asynchronous reset mid-stream, checked before any clock edge
    step(1'b1, 5'd9, 32'h900DF00D, 5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h0BADCAFE, 5'd9, 5'd9);
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rf_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    chk("rst_fwd2_value", fwd2_value, 32'd0);
    sb.delete();
    // Held in reset across an edge with in_valid high: nothing is taken
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1 rst = 1'b1;
    // First posedge after release accepts
    step(1'b1, 5'd12, 32'hCAFE0012, 5'd12, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd12, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
